stfft_framer: RTL and testbench
===============================

Name: stfft_framer

Overview:
- Parametrised STFT front end. Buffers a real sample stream and emits Hann-windowed frames of FFT_SIZE samples every HOP input samples, so overlap is a parameter rather than fixed at 50 %.
- Sits between the audio decimator and fftmain. Output is paced by an FFT-side strobe, so input and output rates are decoupled.
- Flags overrun when the FFT side cannot keep up.

Parameters:
- IW, 14: input sample width, signed.
- OW, 14: output sample width, signed; OW <= IW.
- TW, 14: window coefficient width, unsigned; value/2^TW is in [0,1).
- LGNFFT, 8: log2 of FFT_SIZE; FFT_SIZE = 2^LGNFFT.
- HOP, 128: input samples between frame starts; 1 <= HOP <= FFT_SIZE.
- INITIAL_COEFFS, "hanning.hex": ROM init file holding FFT_SIZE entries of TW bits.

Ports:
- i_clk  in  1  clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ce  in  1  input sample strobe.
- i_sample  in  IW  input sample, signed, qualified by i_ce.
- i_out_ce  in  1  FFT-side strobe; fetches one output sample when a frame is active.
- o_sample  out  OW  windowed sample, signed.
- o_ce  out  1  o_sample valid.
- o_frame  out  1  high with o_ce on tap 0 of each frame.
- o_busy  out  1  high while a frame is being read out.
- o_overrun  out  1  one-cycle pulse when a frame trigger is dropped.

Behaviour:
- Reset: o_sample=0, o_ce=0, o_frame=0, o_busy=0, o_overrun=0. Write pointer, hop counter, primed flag and pending flag are cleared; state is IDLE.
- Sample memory:
  - Ring of 2*FFT_SIZE entries × IW bits; write pointer wp (LGNFFT+1 bits, wraps naturally).
  - On i_ce: mem[wp] <= i_sample, wp++.
- Priming: the primed flag sets on the i_ce that writes the FFT_SIZE-th sample since reset.
- Frame trigger:
  - The hop counter counts i_ce modulo HOP; it starts counting only once primed.
  - A trigger fires on the priming write, then on every HOP-th write after it.
  - Each trigger captures start = wp_after_write − FFT_SIZE.
- Pending:
  - A trigger sets pending and latches start.
  - If pending is already set, the new trigger is dropped, the older start is kept, and o_overrun pulses for 1 cycle.
- FSM:
  - IDLE: if pending, load rd=start and tap=0, clear pending, go to RUN (o_busy=1 from the next cycle).
  - RUN, on each i_out_ce: fetch mem[rd] and coef[tap], then rd++ and tap++.
  - RUN end: after fetching tap FFT_SIZE−1, go to IDLE. If pending is set in that same cycle, go straight to RUN with the new start, with no gap cycle.
  - i_out_ce in IDLE is ignored.
- Pipeline and latency:
  - Stage 1 registers the memory read and the ROM read. Stage 2 registers the multiply and round.
  - o_ce is high exactly 2 clocks after the fetching i_out_ce.
  - o_frame is high with the o_ce of tap 0.
  - o_sample holds its last value when o_ce is low.
- Arithmetic:
  - P = signed(sample) × zero-extended coef, IW+TW+1 bits.
  - o_sample = (P + 2^(IW+TW−OW−1)) >>> (IW+TW−OW), truncated to OW bits. The coefficient is < 1, so no saturation is needed.
- Simultaneous events: i_ce and i_out_ce in the same cycle are legal. Writes never alias the active frame provided readout finishes within FFT_SIZE input samples.
- Reset mid-frame: in-flight o_ce is cancelled from the next cycle. Priming restarts and needs a full FFT_SIZE samples again.

Optional Feature:
- Macro STFFT_WIN_BYPASS_EN.
- Defined: adds input port i_win_bypass (1 bit). When it is high, the coefficient is forced to unity, o_sample = sample >>> (IW−OW), and latency is unchanged.
- Undefined: the port is absent and the ROM coefficient is always used.

Decomposition:
- Package stfft_pkg holds:
  - localparam FFT_SIZE derived from LGNFFT;
  - typedef enum {IDLE, RUN} framer_state_t;
  - a function for the rounding shift amount.
- Sub-module stfft_win_mult: the 1-stage registered multiply, round and truncate (IW, TW, OW). It is reused by a future multichannel variant.

Test Plan:
- Reset: hold i_reset 5 cycles, then feed 255 samples with i_out_ce=1 every cycle -> o_ce stays 0, o_busy=0, all outputs 0.
- Priming (bypass, OW=IW): feed ramp 0..255 -> frame 0..255 appears. o_frame with value 0, o_ce 2 clocks after each i_out_ce, 256 contiguous o_ce.
- Overlap HOP=128: continue ramp 256..383 -> second frame 128..383. With HOP=64, frames start at 0, 64, 128.
- Hann window: constant input 8191, coef file k -> each o_sample equals (8191·coef[k]+8192)>>14. Check o_sample[0]=0 and peak ≈ 8191 at k=128.
- Overrun: i_out_ce=0 through priming plus 2·HOP further samples -> one o_overrun pulse at the third trigger. Releasing i_out_ce then emits frames starting at 0 and 128 back-to-back with no gap cycle.
- Reset mid-frame: assert i_reset at tap 100 -> o_ce=0 from the next cycle. No frame until 256 new samples arrive, and that frame starts with the first post-reset sample.

Source files
------------

// File: rtl/stfft_pkg.sv
// Purpose: shared types, constants and helper functions for the STFT framer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: default FFT size, framer FSM state type, rounding shift helper,
//           Hann coefficient generator used to build the window ROM at elaboration.
package stfft_pkg;

    localparam int DEF_LGNFFT = 8;
    localparam int FFT_SIZE   = 1 << DEF_LGNFFT;

    // pi in Q30, used only by the elaboration-time window generator
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} framer_state_t;

    // Right shift that takes an IW x TW product back to OW bits.
    function automatic int round_shift(input int iw, input int tw, input int ow);
        return iw + tw - ow;
    endfunction

    // Hann coefficient k of an N = 2^lgn point window, round(2^tw * sin^2(pi*k/N)),
    // clamped to 2^tw - 1 so it stays strictly below unity.
    // sin() is a Q30 Taylor series on the folded angle in [0, pi/2].
    function automatic longint hann_coef(input int k, input int lgn, input int tw);
        longint n, m, x, x2, term, s, c;
        n = longint'(1) << lgn;
        m = (longint'(k) <= n / 2) ? longint'(k) : n - longint'(k);
        x = (PI_Q30 * m) / n;
        x2 = (x * x) >>> 30;
        term = x;
        s = x;
        for (int i = 1; i <= 10; i++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1)));
            s = s + term;
        end
        c = ((s * s) + (longint'(1) << (59 - tw))) >>> (60 - tw);
        if (c > (longint'(1) << tw) - 1) c = (longint'(1) << tw) - 1;
        if (c < 0) c = 0;
        return c;
    endfunction

endpackage

// File: rtl/stfft_win_mult.sv
// Purpose: signed sample x unsigned window coefficient, round-half-up, truncate to OW.
// Latency: 1 clock from in_ce to out_ce.
// Backpressure: none; one result per in_ce, result holds while out_ce is low.
// Ports: clk/reset (sync, active high); in_ce, sample, coef, bypass in; out_ce, result out.
module stfft_win_mult
    import stfft_pkg::*;
#(
    parameter int IW = 14,
    parameter int TW = 14,
    parameter int OW = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_ce,
    input  logic signed [IW-1:0] sample,
    input  logic        [TW-1:0] coef,
    input  logic                 bypass,
    output logic                 out_ce,
    output logic signed [OW-1:0] result
);

    localparam int PW = IW + TW + 1;
    localparam int SH = round_shift(IW, TW, OW);
    localparam logic [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (SH - 1);

    logic signed [PW-1:0] prod_mul;
    logic signed [PW-1:0] prod;
    logic        [PW-1:0] rnd;
    logic                 unused_bits;

    assign prod_mul = PW'(sample) * PW'($signed({1'b0, coef}));

    // Unity coefficient is sample << TW; dropping the rounding constant makes the
    // result a plain arithmetic shift of the sample by IW-OW.
    assign prod = bypass ? $signed({sample[IW-1], sample, {TW{1'b0}}}) : prod_mul;
    assign rnd  = prod + (bypass ? {PW{1'b0}} : HALF);

    // Bits [SH +: OW] are (rnd >>> SH) truncated to OW; the coefficient is below
    // unity so the dropped MSB never carries information.
    assign unused_bits = ^{rnd[PW-1], rnd[SH-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_ce <= 1'b0;
            result <= '0;
        end else begin
            out_ce <= in_ce;
            if (in_ce) result <= rnd[SH +: OW];
        end
    end

endmodule

// File: rtl/stfft_framer.sv
// Purpose: STFT front end; ring-buffers samples and reads out Hann-windowed frames every HOP inputs.
// Latency: o_ce 2 clocks after each fetching i_out_ce (memory/ROM read, then multiply/round).
// Backpressure: output paced by i_out_ce; one frame may wait pending, a further trigger is dropped with o_overrun.
// Ports: i_clk, i_reset (sync, active high), i_ce/i_sample in; i_out_ce fetch strobe;
//        o_sample/o_ce/o_frame out, o_busy during readout, o_overrun pulse.
//        Macro STFFT_WIN_BYPASS_EN adds i_win_bypass (unity window, same latency).
module stfft_framer
    import stfft_pkg::*;
#(
    parameter int IW     = 14,
    parameter int OW     = 14,
    parameter int TW     = 14,
    parameter int LGNFFT = DEF_LGNFFT,
    parameter int HOP    = 128
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_sample,
    input  logic                 i_out_ce,
`ifdef STFFT_WIN_BYPASS_EN
    input  logic                 i_win_bypass,
`endif
    output logic signed [OW-1:0] o_sample,
    output logic                 o_ce,
    output logic                 o_frame,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int NFFT = 1 << LGNFFT;
    localparam int AW   = LGNFFT + 1;
    localparam int HW   = (HOP > 1) ? $clog2(HOP) : 1;

    logic signed [IW-1:0] mem [2*NFFT];
    logic        [TW-1:0] coef_rom [NFFT];

    logic [AW-1:0]     wp, start_q, rd;
    logic [LGNFFT-1:0] tap;
    logic [HW-1:0]     hop_cnt;
    logic              primed, pending;
    framer_state_t     state, state_nxt;
    logic              prime_now, trig, accept, drop, load, fetch;
    logic signed [IW-1:0] samp_q;
    logic        [TW-1:0] coef_q;
    logic              s1_ce, s1_frame, s1_byp, win_bypass;

    // Window table built at elaboration, so no init file is needed.
    for (genvar k = 0; k < NFFT; k++) begin : g_rom
        localparam logic [TW-1:0] COEF = TW'(hann_coef(k, LGNFFT, TW));
        assign coef_rom[k] = COEF;
    end

`ifdef STFFT_WIN_BYPASS_EN
    assign win_bypass = i_win_bypass;
`else
    assign win_bypass = 1'b0;
`endif

    // Before priming wp only counts up from 0, so wp == NFFT-1 marks the NFFT-th write.
    assign prime_now = i_ce && !primed && (wp == AW'(NFFT - 1));
    assign trig      = prime_now || (i_ce && primed && (hop_cnt == HW'(HOP - 1)));
    // A trigger landing in the cycle that consumes the pending slot takes the slot.
    assign accept    = trig && (!pending || load);
    assign drop      = trig && pending && !load;
    assign o_busy    = (state == RUN);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fetch     = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_out_ce) begin
                    fetch = 1'b1;
                    if (&tap) begin
                        if (pending) load = 1'b1;      // back-to-back frame, no gap
                        else         state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_ce) mem[wp] <= i_sample;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wp        <= '0;
            hop_cnt   <= '0;
            primed    <= 1'b0;
            pending   <= 1'b0;
            start_q   <= '0;
            state     <= IDLE;
            rd        <= '0;
            tap       <= '0;
            o_overrun <= 1'b0;
            s1_ce     <= 1'b0;
            s1_frame  <= 1'b0;
            s1_byp    <= 1'b0;
            samp_q    <= '0;
            coef_q    <= '0;
            o_frame   <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_overrun <= drop;
            if (i_ce) begin
                wp <= wp + 1'b1;
                if (prime_now) primed <= 1'b1;
                if (primed) hop_cnt <= (hop_cnt == HW'(HOP - 1)) ? '0 : hop_cnt + 1'b1;
            end
            if (accept) begin
                pending <= 1'b1;
                start_q <= wp + AW'(1) - AW'(NFFT);
            end else if (load) begin
                pending <= 1'b0;
            end
            if (load) begin
                rd  <= start_q;
                tap <= '0;
            end else if (fetch) begin
                rd  <= rd + 1'b1;
                tap <= tap + 1'b1;
            end
            s1_ce    <= fetch;
            s1_frame <= fetch && (tap == '0);
            if (fetch) begin
                samp_q <= mem[rd];
                coef_q <= coef_rom[tap];
                s1_byp <= win_bypass;
            end
            o_frame <= s1_frame;
        end
    end

    stfft_win_mult #(
        .IW (IW),
        .TW (TW),
        .OW (OW)
    ) u_win_mult (
        .clk    (i_clk),
        .reset  (i_reset),
        .in_ce  (s1_ce),
        .sample (samp_q),
        .coef   (coef_q),
        .bypass (s1_byp),
        .out_ce (o_ce),
        .result (o_sample)
    );

endmodule

// File: tb/tb_stfft_framer.sv
// Purpose: directed self-checking bench for stfft_framer at default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_stfft_framer;
    import stfft_pkg::*;

    logic clk = 1'b0;
    logic rst, ce, out_ce;
    logic signed [13:0] smp;
    logic signed [13:0] o_sample;
    logic o_ce, o_frame, o_busy, o_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int q_val[$];
    int q_frm[$];
    int q_cyc[$];

    always #5 clk = ~clk;

    stfft_framer dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_ce         (ce),
        .i_sample     (smp),
        .i_out_ce     (out_ce),
`ifdef STFFT_WIN_BYPASS_EN
        .i_win_bypass (1'b0),
`endif
        .o_sample     (o_sample),
        .o_ce         (o_ce),
        .o_frame      (o_frame),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    // Output log, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (o_ce) begin
            q_val.push_back(int'(o_sample));
            q_frm.push_back(int'(o_frame));
            q_cyc.push_back(cyc);
        end
        if (o_overrun) ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed(input int v);
        ce  = 1'b1;
        smp = 14'(v);
        tick();
        ce  = 1'b0;
    endtask

    task automatic read_out(input int n);
        out_ce = 1'b1;
        repeat (n) tick();
        out_ce = 1'b0;
        repeat (3) tick();
    endtask

    // Hand-known Hann values for N=256, TW=14: w[0]=0, w[64]=w[192]=0.5, w[128] clamps to 16383.
    function automatic int exp_out(input int k, input int x);
        int c;
        case (k)
            64:      c = 8192;
            128:     c = 16383;
            192:     c = 8192;
            default: c = 0;
        endcase
        return (x * c + 8192) >>> 14;
    endfunction

    task automatic chk_frame(input string tag, input int idx, input int base, input bit ramp);
        int nfrm;
        if (q_val.size() < idx + 256) begin
            chk({tag, "_len"}, q_val.size() - idx, 256);
        end else begin
            nfrm = 0;
            for (int k = 0; k < 256; k++) nfrm += q_frm[idx + k];
            chk({tag, "_first"}, q_frm[idx], 1);
            chk({tag, "_nframe"}, nfrm, 1);
            chk({tag, "_contig"}, q_cyc[idx + 255] - q_cyc[idx], 255);
            for (int k = 0; k < 256; k += 64)
                chk($sformatf("%s_tap%0d", tag, k), q_val[idx + k],
                    exp_out(k, ramp ? base + k : base));
        end
    endtask

    initial begin
        int idx, ovr0, ceb;
        rst = 1'b1; ce = 1'b0; out_ce = 1'b0; smp = '0;

        // Reset state
        repeat (5) tick();
        chk("rst_sample", int'(o_sample), 0);
        chk("rst_ce", int'(o_ce), 0);
        chk("rst_frame", int'(o_frame), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        rst = 1'b0;

        // 255 samples are not enough to prime: strobes are ignored
        out_ce = 1'b1;
        for (int i = 0; i < 255; i++) feed(i);
        out_ce = 1'b0;
        repeat (3) tick();
        chk("preprime_no_ce", q_val.size(), 0);
        chk("preprime_busy", int'(o_busy), 0);
        chk("preprime_sample", int'(o_sample), 0);

        // 256th sample primes and triggers; busy one cycle later
        feed(255);
        chk("prime_busy_same", int'(o_busy), 0);
        tick();
        chk("prime_busy_next", int'(o_busy), 1);

        // Latency: o_ce exactly two clocks after the first fetch
        idx = q_val.size();
        out_ce = 1'b1;
        tick();
        chk("lat_1clk_ce", int'(o_ce), 0);
        tick();
        chk("lat_2clk_ce", int'(o_ce), 1);
        chk("lat_2clk_frame", int'(o_frame), 1);
        chk("lat_2clk_tap0", int'(o_sample), 0);
        repeat (254) tick();
        out_ce = 1'b0;
        chk("f0_busy_end", int'(o_busy), 0);
        repeat (3) tick();
        chk("f0_count", q_val.size() - idx, 256);
        chk_frame("f0", idx, 0, 1'b1);

        // HOP=128 overlap: next frame starts at sample 128
        for (int i = 256; i < 384; i++) feed(i);
        tick();
        idx = q_val.size();
        read_out(256);
        chk("f1_count", q_val.size() - idx, 256);
        chk_frame("f1", idx, 128, 1'b1);

        // Overrun: no readout during priming plus two hops
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        ovr0 = ovr_cnt;
        for (int i = 0; i < 511; i++) feed(i);
        chk("ovr_none_early", ovr_cnt - ovr0, 0);
        feed(511);
        chk("ovr_pulse", int'(o_overrun), 1);
        tick();
        chk("ovr_one_cycle", int'(o_overrun), 0);
        chk("ovr_count", ovr_cnt - ovr0, 1);
        idx = q_val.size();
        read_out(512);
        chk("ovr_two_frames", q_val.size() - idx, 512);
        chk("ovr_busy_end", int'(o_busy), 0);
        chk_frame("ovr_fA", idx, 0, 1'b1);
        chk_frame("ovr_fB", idx + 256, 128, 1'b1);
        if (q_cyc.size() >= idx + 257)
            chk("ovr_no_gap", q_cyc[idx + 256] - q_cyc[idx + 255], 1);

        // Window shape on constant full-scale input
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) feed(8191);
        tick();
        idx = q_val.size();
        read_out(256);
        chk_frame("hann", idx, 8191, 1'b0);

        // Reset mid-frame at tap 100
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) feed(1000 + i);
        tick();
        out_ce = 1'b1;
        repeat (101) tick();
        chk("mid_ce_before", int'(o_ce), 1);
        rst = 1'b1;
        out_ce = 1'b0;
        tick();
        chk("mid_ce_cut", int'(o_ce), 0);
        chk("mid_busy_cut", int'(o_busy), 0);
        rst = 1'b0;
        ceb = q_val.size();
        out_ce = 1'b1;
        for (int i = 0; i < 255; i++) feed(2000 + i);
        out_ce = 1'b0;
        chk("mid_no_early_frame", q_val.size() - ceb, 0);
        chk("mid_no_early_busy", int'(o_busy), 0);
        feed(2255);
        tick();
        idx = q_val.size();
        read_out(256);
        chk_frame("post_rst", idx, 2000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
